// File: rtl/seven_seg_pkg.sv
// Shared definitions for the seven-segment digit scanner: FSM state
// encoding, default digit count and a width helper for counters/indices.
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  localparam int unsigned SEG_DIGITS_DEFAULT = 4;

  // Bits needed to index v distinct values (never less than 1).
  function automatic int unsigned clog2_min1(input int unsigned v);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_timer.sv
// seg_scan_timer: loadable down-counter for the scanner FSM.
// Loaded with a phase length L, tc asserts in the L-th cycle of the phase.
// A count of 0 only occurs after reset (idle) and means "not yet loaded".
module seg_scan_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc,
  output logic         idle
);

  logic [W-1:0] cnt;

  // Count down towards 1; reload whenever the FSM requests it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt > W'(1)) begin
      cnt <= cnt - W'(1);
    end
  end

  // Terminal-count and unloaded flags.
  always_comb begin
    tc   = (cnt == W'(1));
    idle = (cnt == '0);
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexes a DIGITS-nibble value onto a single
// shared seven-segment decoder, with dark guard gaps between digits and a
// frame-synchronous double buffer so the display never tears.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIGITS = SEG_DIGITS_DEFAULT,
  parameter int unsigned DIV    = 1000,
  parameter int unsigned GUARD  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  output logic [3:0]            nibble,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame
);

  localparam int unsigned VW      = 4 * DIGITS;
  localparam int unsigned CNT_MAX = (DIV > GUARD) ? DIV : GUARD;
  localparam int unsigned CNT_W   = clog2_min1(CNT_MAX + 1);
  localparam int unsigned IDX_W   = clog2_min1(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  scan_state_t        state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [VW-1:0]      pending_val, pending_val_nxt;
  logic [DIGITS-1:0]  pending_dp, pending_dp_nxt;
  logic [VW-1:0]      active_val, active_val_nxt;
  logic [DIGITS-1:0]  active_dp, active_dp_nxt;

  logic               tmr_load;
  logic [CNT_W-1:0]   tmr_val;
  logic               tc;
  logic               idle;
  logic               advance;
  logic               go_show;
  logic               frame_edge;

  logic               lit_nxt;
  logic [3:0]         nibble_nxt;
  logic               dp_nxt;
  logic [DIGITS-1:0]  digit_en_nxt;

  seg_scan_timer #(
    .W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tc),
    .idle     (idle)
  );

`ifdef SEG_SCAN_LZB_EN
  // A digit is visible unless it and every more-significant nibble are zero
  // and its own decimal point is off; digit 0 is always visible.
  function automatic logic digit_visible(input logic [VW-1:0]     v,
                                         input logic [DIGITS-1:0] d,
                                         input logic [IDX_W-1:0]  i);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (k >= 32'(i) && v[4*k +: 4] != 4'h0) upper_zero = 1'b0;
    end
    return (i == '0) || d[i] || !upper_zero;
  endfunction
`endif

  // State, buffers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BLANK;
      idx         <= '0;
      pending_val <= '0;
      pending_dp  <= '0;
      active_val  <= '0;
      active_dp   <= '0;
      nibble      <= '0;
      dp          <= 1'b0;
      digit_en    <= '0;
      frame       <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      pending_val <= pending_val_nxt;
      pending_dp  <= pending_dp_nxt;
      active_val  <= active_val_nxt;
      active_dp   <= active_dp_nxt;
      nibble      <= nibble_nxt;
      dp          <= dp_nxt;
      digit_en    <= digit_en_nxt;
      frame       <= frame_edge;
    end
  end

  // Next state, digit index, timer reload and frame-boundary buffer swap.
  // The post-reset BLANK phase starts with an unloaded timer; it is loaded
  // on the first cycle so digit 0 still lights exactly GUARD cycles in.
  always_comb begin
    advance   = (state == SHOW) && tc;
    go_show   = 1'b0;
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    idx_nxt   = idx;
    if (advance) idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);

    unique case (state)
      BLANK: begin
        if (GUARD == 0 || tc) begin
          go_show = 1'b1;
        end else if (idle) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GUARD);
        end
      end
      SHOW: begin
        if (advance) begin
          if (GUARD == 0) begin
            go_show = 1'b1;
          end else begin
            state_nxt = BLANK;
            tmr_load  = 1'b1;
            tmr_val   = CNT_W'(GUARD);
          end
        end
      end
    endcase

    if (go_show) begin
      state_nxt = SHOW;
      tmr_load  = 1'b1;
      tmr_val   = CNT_W'(DIV);
    end

    frame_edge      = go_show && (idx_nxt == '0);
    pending_val_nxt = load ? value : pending_val;
    pending_dp_nxt  = load ? dp_in : pending_dp;
    // A load on the frame edge itself bypasses straight into active.
    active_val_nxt  = frame_edge ? pending_val_nxt : active_val;
    active_dp_nxt   = frame_edge ? pending_dp_nxt  : active_dp;
  end

  // Output decode for the upcoming cycle: one-hot enable plus digit data.
  always_comb begin
    lit_nxt = 1'b1;
`ifdef SEG_SCAN_LZB_EN
    lit_nxt = digit_visible(active_val_nxt, active_dp_nxt, idx_nxt);
`endif
    digit_en_nxt = '0;
    nibble_nxt   = '0;
    dp_nxt       = 1'b0;
    if (state_nxt == SHOW && lit_nxt) begin
      digit_en_nxt[idx_nxt] = 1'b1;
      nibble_nxt            = active_val_nxt[{idx_nxt, 2'b00} +: 4];
      dp_nxt                = active_dp_nxt[idx_nxt];
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (DIGITS=4, DIV=3, GUARD=2),
// plus a second instance with GUARD=0. Honours SEG_SCAN_LZB_EN when defined.
module tb_seven_segment_scanner;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIV     = 3;
  localparam int unsigned GUARD   = 2;
  localparam int unsigned SLOT    = DIV + GUARD;
  localparam int unsigned PERIOD  = DIGITS * SLOT;
  localparam int unsigned PERIOD0 = DIGITS * DIV;
  localparam int NV = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;

  logic [3:0]  nibble, nibble0;
  logic        dp, dp0;
  logic [3:0]  digit_en, digit_en0;
  logic        frame, frame0;

  int unsigned checks = 0;
  int unsigned passes = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  lit_lzb;
  } vec_t;

  vec_t vecs[NV];

  always #5 clk = ~clk;

  seven_segment_scanner #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(GUARD)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .nibble(nibble), .dp(dp), .digit_en(digit_en), .frame(frame)
  );

  seven_segment_scanner #(.DIGITS(DIGITS), .DIV(DIV), .GUARD(0)) dut0 (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
    .nibble(nibble0), .dp(dp0), .digit_en(digit_en0), .frame(frame0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [3:0] lit_of(input vec_t v);
`ifdef SEG_SCAN_LZB_EN
    return v.lit_lzb;
`else
    return 4'hF;
`endif
  endfunction

  function automatic bit lit_model(input logic [15:0] v, input logic [3:0] d, input int s);
`ifdef SEG_SCAN_LZB_EN
    if (s == 0 || d[s]) return 1'b1;
    return (v >> (4 * s)) != 16'h0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic wait_frame(input int unsigned budget, output int unsigned n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame && n < budget);
    chk("frame_seen", 32'(frame), 32'd1);
  endtask

  // Called at the first negedge of a frame; walks the whole frame.
  task automatic check_frame(input vec_t v, input bit do_load, input vec_t nv, input string tag);
    logic [3:0] lit;
    lit = lit_of(v);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < int'(SLOT); c++) begin
        if (!(s == 0 && c == 0)) @(negedge clk);
        if (do_load && s == 0 && c == 0) begin
          load = 1'b1; value = nv.value; dp_in = nv.dp;
        end else begin
          load = 1'b0;
        end
        chk({tag, "_frame"}, 32'(frame), 32'((s == 0 && c == 0) ? 1 : 0));
        if (c < int'(DIV)) begin
          chk({tag, "_en"}, 32'(digit_en), 32'(lit[s] ? (4'b0001 << s) : 4'b0000));
          if (lit[s]) begin
            chk({tag, "_nibble"}, 32'(nibble), 32'(v.value[4*s +: 4]));
            chk({tag, "_dp"}, 32'(dp), 32'(v.dp[s]));
          end
        end else begin
          chk({tag, "_guard"}, 32'(digit_en), 32'd0);
        end
      end
    end
  endtask

  // GUARD=0 instance: period and no dark cycles once running.
  int unsigned since0 = 0;
  bit seen0 = 1'b0;
  bit lit_seen0 = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      since0 = 0; seen0 = 1'b0; lit_seen0 = 1'b0;
    end else begin
      since0++;
      if (frame0) begin
        if (seen0) chk("g0_period", since0, PERIOD0);
        seen0 = 1'b1;
        since0 = 0;
      end
`ifndef SEG_SCAN_LZB_EN
      if (lit_seen0) chk("g0_never_dark", 32'(digit_en0 != 4'h0), 32'd1);
`endif
      if (digit_en0 != 4'h0) lit_seen0 = 1'b1;
      chk("g0_onehot", 32'($countones(digit_en0) <= 1), 32'd1);
    end
  end

  initial begin
    int unsigned n;
    vec_t v5555, vzero;
    logic [15:0] pv, av;
    logic [3:0]  pd, ad;
    logic [31:0] exp_en;
    int s, pos;

    vecs[0] = '{16'h4321, 4'b0100, 4'b1111};
    vecs[1] = '{16'h0050, 4'b0000, 4'b0011};
    vecs[2] = '{16'h0000, 4'b0000, 4'b0001};
    vecs[3] = '{16'h0000, 4'b1000, 4'b1001};
    vecs[4] = '{16'hF0E9, 4'b0001, 4'b1111};
    vecs[5] = '{16'h0B00, 4'b0010, 4'b0111};
    vecs[6] = '{16'h000A, 4'b0100, 4'b0101};
    vecs[7] = '{16'hAAAA, 4'b0000, 4'b1111};
    v5555   = '{16'h5555, 4'b1010, 4'b1111};
    vzero   = '{16'h0000, 4'b0000, 4'b0001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_en", 32'(digit_en), 32'd0);
    chk("rst_nibble", 32'(nibble), 32'd0);
    chk("rst_dp", 32'(dp), 32'd0);
    chk("rst_frame", 32'(frame), 32'd0);
    chk("rst_en0", 32'(digit_en0), 32'd0);

    // Release; load the first value so it is captured at cycle 0
    rst = 1'b0;
    load = 1'b1; value = vecs[0].value; dp_in = vecs[0].dp;
    @(negedge clk);
    load = 1'b0;
    chk("c0_dark", 32'(digit_en), 32'd0);
    chk("c0_frame", 32'(frame), 32'd0);
    chk("g0_c0_en", 32'(digit_en0), 32'd1);
    chk("g0_c0_frame", 32'(frame0), 32'd1);
    @(negedge clk);
    chk("c1_dark", 32'(digit_en), 32'd0);
    @(negedge clk);
    chk("c2_frame", 32'(frame), 32'd1);
    chk("c2_en", 32'(digit_en), 32'd1);
    check_frame(vecs[0], 1'b0, vecs[0], "f1");

    // Table: each new value loaded mid-frame must not disturb that frame
    for (int i = 1; i < NV; i++) begin
      wait_frame(PERIOD + 2, n);
      chk("period_old", n, 32'd1);
      check_frame(vecs[i-1], 1'b1, vecs[i], "old");
      wait_frame(PERIOD + 2, n);
      chk("period_new", n, 32'd1);
      check_frame(vecs[i], 1'b0, vecs[i], "new");
    end

    // Load coinciding with the frame edge shows in that same frame
    load = 1'b1; value = v5555.value; dp_in = v5555.dp;
    wait_frame(PERIOD + 2, n);
    chk("period_bypass", n, 32'd1);
    check_frame(v5555, 1'b0, v5555, "bypass");

    // Asynchronous reset mid-SHOW, then restart as from power-up
    wait_frame(PERIOD + 2, n);
    @(negedge clk);
    chk("pre_rst_en", 32'(digit_en), 32'd1);
    chk("pre_rst_nibble", 32'(nibble), 32'h5);
    rst = 1'b1;
    #1;
    chk("arst_en", 32'(digit_en), 32'd0);
    chk("arst_nibble", 32'(nibble), 32'd0);
    chk("arst_dp", 32'(dp), 32'd0);
    chk("arst_frame", 32'(frame), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rr_c0_dark", 32'(digit_en), 32'd0);
    @(negedge clk);
    chk("rr_c1_dark", 32'(digit_en), 32'd0);
    @(negedge clk);
    chk("rr_c2_frame", 32'(frame), 32'd1);
    check_frame(vzero, 1'b0, vzero, "rr");

    // 100 frames with random loads against a small buffer model
    pv = '0; pd = '0;
    wait_frame(PERIOD + 2, n);
    chk("period_rnd0", n, 32'd1);
    for (int f = 0; f < 100; f++) begin
      av = pv; ad = pd;
      for (int c = 0; c < int'(PERIOD); c++) begin
        if (c > 0) @(negedge clk);
        s = c / int'(SLOT);
        pos = c % int'(SLOT);
        exp_en = (pos < int'(DIV) && lit_model(av, ad, s)) ? (32'd1 << s) : 32'd0;
        chk("rnd_frame", 32'(frame), 32'((c == 0) ? 1 : 0));
        chk("rnd_en", 32'(digit_en), exp_en);
        if (exp_en != 0) begin
          chk("rnd_nibble", 32'(nibble), 32'((av >> (4 * s)) & 16'hF));
          chk("rnd_dp", 32'(dp), 32'(ad[s]));
        end
        if ($urandom_range(0, 3) == 0) begin
          load = 1'b1; value = 16'($urandom); dp_in = 4'($urandom);
          pv = value; pd = dp_in;
        end else begin
          load = 1'b0;
        end
      end
      @(negedge clk);
    end
    load = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
